pipelined_divider_stream: RTL and testbench

PIPELINED_DIVIDER_STREAM -- requirements
Module: pipelined_divider_stream

---
 rtl/pipelined_divider_stream.sv | 139 +++++++++++++
 tb/tb_pipelined_divider_stream.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_divider_stream.sv
// Streaming restoring divider: one operation per cycle, signed/unsigned per op,
// sign fix-up and divide-by-zero handling in the last stage, global stall on !out_ready.

module pipelined_divider_stream_step #(
  parameter int W   = 32,
  parameter int BPS = 1
) (
  input  logic [W-1:0] r_i,
  input  logic [W-1:0] q_i,
  input  logic [W:0]   d,
  output logic [W-1:0] r_o,
  output logic [W-1:0] q_o
);
  logic [W-1:0] r, q;
  logic [W:0]   t;

  // q starts as the numerator magnitude; its MSBs shift into r while quotient bits fill from the right
  always_comb begin
    r = r_i;
    q = q_i;
    t = '0;
    for (int i = 0; i < BPS; i++) begin
      t = {r, q[W-1]};
      q = {q[W-2:0], 1'b0};
      if (t >= d) begin
        r    = W'(t - d);
        q[0] = 1'b1;
      end else begin
        r = t[W-1:0];
      end
    end
    r_o = r;
    q_o = q;
  end
endmodule

module pipelined_divider_stream #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_STAGE = 1,
  parameter int TAG_WIDTH      = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_signed,
  input  logic [DATA_WIDTH-1:0] numer,
  input  logic [DATA_WIDTH-1:0] denom,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remain,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  div_by_zero
);
  localparam int W       = DATA_WIDTH;
  localparam int NS      = DATA_WIDTH / BITS_PER_STAGE;
  localparam int LATENCY = NS + 2;
  localparam int STAGES  = LATENCY - 1;

  typedef struct packed {
    logic [W-1:0]         r;
    logic [W-1:0]         q;
    logic [W:0]           d;
    logic                 sn;
    logic                 sd;
    logic                 dz;
    logic [TAG_WIDTH-1:0] tag;
  } stage_t;

  // vld_pipe[0] is stage 0, vld_pipe[STAGES] is the presented result
  logic [STAGES:0] vld_pipe;
  logic            advance;
  stage_t          st [NS+1];

  assign advance   = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     vld_pipe <= '0;
    else if (advance) vld_pipe <= {vld_pipe[STAGES-1:0], in_valid && in_ready};
  end

  logic         sn0, sd0;
  logic [W-1:0] nmag;
  logic [W:0]   dmag;

  assign sn0  = in_signed & numer[W-1];
  assign sd0  = in_signed & denom[W-1];
  // |most-negative| = 2^(W-1) is exact as a W-bit unsigned value
  assign nmag = sn0 ? -numer : numer;
  assign dmag = sd0 ? -{1'b1, denom} : {1'b0, denom};

  always_ff @(posedge clock) begin
    if (advance)
      st[0] <= '{r: '0, q: nmag, d: dmag, sn: sn0, sd: sd0, dz: (denom == '0), tag: in_tag};
  end

  for (genvar k = 1; k <= NS; k++) begin : g_stage
    logic [W-1:0] r_n, q_n;

    pipelined_divider_stream_step #(.W(W), .BPS(BITS_PER_STAGE)) u_step (
      .r_i (st[k-1].r),
      .q_i (st[k-1].q),
      .d   (st[k-1].d),
      .r_o (r_n),
      .q_o (q_n)
    );

    always_ff @(posedge clock) begin
      if (advance) begin
        st[k]   <= st[k-1];
        st[k].r <= r_n;
        st[k].q <= q_n;
      end
    end
  end

  // With d = 0 every step subtracts nothing: q becomes all ones and r ends as |numer|,
  // so re-applying the numerator sign already yields remain = numer.
  logic [W-1:0] qf, rf;

  always_comb begin
    qf = (st[NS].sn ^ st[NS].sd) ? -st[NS].q : st[NS].q;
    if (st[NS].dz) qf = '1;
    rf = st[NS].sn ? -st[NS].r : st[NS].r;
  end

  always_ff @(posedge clock) begin
    if (advance) begin
      quotient    <= qf;
      remain      <= rf;
      out_tag     <= st[NS].tag;
      div_by_zero <= st[NS].dz;
    end
  end
endmodule

// File: tb/tb_pipelined_divider_stream.sv
// Scoreboard bench for pipelined_divider_stream: directed corner cases, random stream
// with back-pressure, full-pipe stall/drain and mid-flight reset.

module tb_pipelined_divider_stream;
  localparam int W   = 32;
  localparam int BPS = 1;
  localparam int TW  = 4;
  localparam int LAT = W / BPS + 2;

  logic          clock = 1'b0, reset_n = 1'b0;
  logic          in_valid = 1'b0, in_ready, in_signed = 1'b0;
  logic [W-1:0]  numer = '0, denom = '0, quotient, remain;
  logic [TW-1:0] in_tag = '0, out_tag;
  logic          out_valid, out_ready = 1'b1, div_by_zero;

  typedef struct packed {
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic [TW-1:0] tag;
    logic          dz;
  } res_t;

  res_t sb[$];
  int   vectors = 0, miscompares = 0, out_cnt = 0;

  always #5 clock = ~clock;

  pipelined_divider_stream #(.DATA_WIDTH(W), .BITS_PER_STAGE(BPS), .TAG_WIDTH(TW)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .numer(numer), .denom(denom), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient), .remain(remain),
    .out_tag(out_tag), .div_by_zero(div_by_zero)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic res_t model(input logic sgn, input logic [W-1:0] n, input logic [W-1:0] d,
                                 input logic [TW-1:0] tag);
    res_t   m;
    longint sn, sd, tq, tr;
    m.tag = tag;
    m.dz  = (d == '0);
    if (d == '0) begin
      m.q = '1;
      m.r = n;
    end else if (!sgn) begin
      m.q = n / d;
      m.r = n % d;
    end else begin
      sn  = longint'($signed(n));
      sd  = longint'($signed(d));
      tq  = sn / sd;
      tr  = sn % sd;
      m.q = tq[W-1:0];
      m.r = tr[W-1:0];
    end
    return m;
  endfunction

  // output side: pop on handshake, and hold-stability while stalled
  res_t hold;
  bit   hold_v = 1'b0;
  always @(negedge clock) begin
    res_t e;
    if (!reset_n) hold_v = 1'b0;
    else begin
      if (hold_v) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_qr", {quotient, remain}, {hold.q, hold.r});
        chk("stall_tagdz", 64'({out_tag, div_by_zero}), 64'({hold.tag, hold.dz}));
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (sb.size() == 0) chk("spurious_out", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          chk("quotient", 64'(quotient), 64'(e.q));
          chk("remain", 64'(remain), 64'(e.r));
          chk("out_tag", 64'(out_tag), 64'(e.tag));
          chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
        end
      end
      hold_v = out_valid && !out_ready;
      hold   = '{q: quotient, r: remain, tag: out_tag, dz: div_by_zero};
    end
  end

  // Call at posedge+#1; returns at posedge+#1 right after the accepting edge.
  task automatic send(input logic sgn, input logic [W-1:0] n, input logic [W-1:0] d,
                      input logic [TW-1:0] tag, input res_t exp);
    int c;
    c = 0;
    in_valid = 1'b1; in_signed = sgn; numer = n; denom = d; in_tag = tag;
    #1;
    while (!in_ready && c < 200) begin
      @(posedge clock); #1;
      c++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    else sb.push_back(exp);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_exp(input logic sgn, input logic [W-1:0] n, input logic [W-1:0] d,
                          input logic [TW-1:0] tag, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input logic edz);
    send(sgn, n, d, tag, '{q: eq, r: er, tag: tag, dz: edz});
  endtask

  task automatic send_model(input logic sgn, input logic [W-1:0] n, input logic [W-1:0] d,
                            input logic [TW-1:0] tag);
    send(sgn, n, d, tag, model(sgn, n, d, tag));
  endtask

  // Accepting edge counts as edge 0; the result is visible LAT-1 edges later,
  // i.e. during the LAT-th cycle counting the acceptance cycle.
  task automatic lat_check(input string name);
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 200) begin
      @(posedge clock); #1;
      cnt++;
    end
    chk(name, 64'(cnt), 64'(LAT - 1));
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && c < 500) begin
      @(posedge clock); #1;
      c++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int acc, filled, base;
    logic [W-1:0] n, d;
    logic         s;

    // an op offered during reset must never appear
    in_valid = 1'b1; in_signed = 1'b1; numer = 32'd99; denom = 32'd3; in_tag = 4'hF;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    #8 in_valid = 1'b0;
    #2 reset_n = 1'b1;

    // first edge after release accepts
    send_exp(1'b1, 32'd7, 32'hFFFFFFFE, 4'd3, 32'hFFFFFFFD, 32'd1, 1'b0);
    lat_check("latency_7_-2");
    wait_drain();

    send_exp(1'b1, 32'hFFFFFFF9, 32'd2, 4'd5, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    send_exp(1'b0, 32'hFFFFFFF9, 32'd2, 4'd6, 32'h7FFFFFFC, 32'd1, 1'b0);
    send_exp(1'b1, 32'h80000000, 32'hFFFFFFFF, 4'd7, 32'h80000000, 32'd0, 1'b0);
    send_exp(1'b1, 32'd5, 32'd0, 4'd8, 32'hFFFFFFFF, 32'd5, 1'b1);
    send_exp(1'b0, 32'd5, 32'd0, 4'd9, 32'hFFFFFFFF, 32'd5, 1'b1);
    send_exp(1'b1, 32'hFFFFFFFB, 32'd0, 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);
    send_exp(1'b0, 32'hFFFFFFFF, 32'd1, 4'd11, 32'hFFFFFFFF, 32'd0, 1'b0);
    send_exp(1'b1, 32'h80000000, 32'd1, 4'd12, 32'h80000000, 32'd0, 1'b0);
    send_exp(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 4'd13, 32'd3, 32'hFFFFFFFF, 1'b0);
    wait_drain();

    // random stream with random back-pressure
    acc = 0;
    for (int c = 0; c < 3000 && acc < 100; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      n = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       d = '0;
        1:       d = '1;
        2:       d = 32'($urandom_range(1, 15));
        default: d = $urandom >> $urandom_range(0, 31);
      endcase
      in_signed = s; numer = n; denom = d; in_tag = 4'($urandom);
      #1;
      if (in_valid && in_ready) begin
        sb.push_back(model(s, n, d, in_tag));
        acc++;
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    chk("rand_accepted", 64'(acc), 64'd100);
    wait_drain();

    // fill with out_ready low, then drain one per cycle
    out_ready = 1'b0;
    filled = 0;
    for (int c = 0; c < 100; c++) begin
      in_valid = 1'b1; in_signed = 1'(c % 2); numer = 32'(1000 + 7 * c);
      denom = 32'(c + 1); in_tag = 4'(c);
      #1;
      if (!in_ready) break;
      sb.push_back(model(in_signed, numer, denom, in_tag));
      filled++;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    chk("fill_count", 64'(filled), 64'(LAT));
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    repeat (5) @(posedge clock);
    #1;
    out_ready = 1'b1;
    base = out_cnt;
    repeat (LAT) @(posedge clock);
    #1;
    chk("drain_rate", 64'(out_cnt - base), 64'(LAT));
    chk("drain_empty", 64'(out_valid), 64'd0);
    wait_drain();

    // reset with 10 ops in flight, oldest stalled at the output
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      send_model(1'b0, 32'(500 + i), 32'd7, 4'(i));
    for (int c = 0; c < 100 && !out_valid; c++) begin
      @(posedge clock); #1;
    end
    chk("preflush_out_valid", 64'(out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1 chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(posedge clock); #2;
    reset_n = 1'b1;
    out_ready = 1'b1;
    base = out_cnt;
    repeat (40) @(posedge clock);
    #1;
    chk("no_stale_out", 64'(out_cnt - base), 64'd0);
    send_exp(1'b0, 32'd20, 32'd3, 4'd2, 32'd6, 32'd2, 1'b0);
    lat_check("latency_20_3");
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
